// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and serializes each byte as 8N1 on tx.
// Line output is registered from the next-state decision so the start bit lands two cycles after the pop.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          baud_tc;

    assign baud_tc    = (baud_cnt == LAST);
    assign busy       = (state != IDLE);
    // Gated by rst so the strobe drops the instant reset is applied.
    assign fifo_rd_en = ~rst & (state == IDLE) & tx_en & ~fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (fifo_rd_en) state <= FETCH;
                end
                FETCH: begin
                    shift_reg <= fifo_data;
                    bit_cnt   <= '0;
                    baud_cnt  <= '0;
                    tx        <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Next bit is the one about to shift into position 0.
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: queue-based FIFO model, per-cycle line history and a
// sampling UART receiver that decodes frames from that history.
module tb_fifo_uart_tx;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en, tx, busy, tx_done;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int bad_rd = 0;
    int stop_err = 0;
    logic last_tx, last_busy, last_rd;
    logic txh [1024];
    logic busyh [1024];
    int rd_q[$], done_q[$], start_q[$], byte_q[$];
    logic [7:0] fq[$];
    logic [7:0] eb;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx),
        .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic clr();
        ncyc = 0;
        rd_q.delete(); done_q.delete(); start_q.delete(); byte_q.delete();
    endtask

    // One clock: sample at the falling edge, then let the FIFO model react to the pop.
    task automatic cyc();
        logic pop;
        @(negedge clk);
        last_tx = tx; last_busy = busy; last_rd = fifo_rd_en;
        if (ncyc < 1024) begin txh[ncyc] = tx; busyh[ncyc] = busy; end
        if (fifo_rd_en && fifo_empty) bad_rd++;
        if (fifo_rd_en) rd_q.push_back(ncyc);
        if (tx_done) done_q.push_back(ncyc);
        pop = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop && fq.size() > 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        ncyc++;
    endtask

    task automatic decode();
        int i;
        int b;
        i = 1;
        start_q.delete(); byte_q.delete();
        while (i + 10*C < ncyc && i + 10*C < 1024) begin
            if (txh[i-1] === 1'b1 && txh[i] === 1'b0) begin
                b = 0;
                for (int k = 0; k < 8; k++)
                    if (txh[i + (k+1)*C + C/2] === 1'b1) b |= (1 << k);
                if (txh[i + 9*C + C/2] !== 1'b1) stop_err++;
                start_q.push_back(i);
                byte_q.push_back(b);
                i += 10*C;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        // Reset held with a ready byte and permission: nothing may leave.
        rst = 1'b1; tx_en = 1'b1; push(8'hA5);
        repeat (3) begin
            cyc();
            chk("rst_tx", last_tx, 1);
            chk("rst_busy", last_busy, 0);
            chk("rst_rd_en", last_rd, 0);
        end
        rst = 1'b0;
        clr();
        repeat (50) cyc();
        decode();
        chk("t1_pops", rd_q.size(), 1);
        chk("t1_pop_cyc", qi(rd_q, 0), 0);
        chk("t1_idle_tx0", txh[0], 1);
        chk("t1_fetch_tx", txh[1], 1);
        eb = 8'hA5;
        for (int j = 0; j < 40; j++) begin
            logic e;
            if (j < 4) e = 1'b0;
            else if (j < 36) e = eb[(j-4)/4];
            else e = 1'b1;
            chk($sformatf("t1_tx_c%0d", j+2), txh[j+2], e);
        end
        chk("t1_busy_c0", busyh[0], 0);
        chk("t1_busy_c1", busyh[1], 1);
        chk("t1_busy_c41", busyh[41], 1);
        chk("t1_busy_c42", busyh[42], 0);
        chk("t1_done_n", done_q.size(), 1);
        chk("t1_done_cyc", qi(done_q, 0), 42);
        chk("t1_frames", byte_q.size(), 1);
        chk("t1_byte", qi(byte_q, 0), 32'hA5);
        chk("t1_start", qi(start_q, 0), 2);

        // Back-to-back frames.
        clr();
        push(8'h00); push(8'hFF); push(8'h3C);
        repeat (3*42 + 20) cyc();
        decode();
        chk("b2b_frames", byte_q.size(), 3);
        chk("b2b_byte0", qi(byte_q, 0), 32'h00);
        chk("b2b_byte1", qi(byte_q, 1), 32'hFF);
        chk("b2b_byte2", qi(byte_q, 2), 32'h3C);
        chk("b2b_start0", qi(start_q, 0), 2);
        chk("b2b_gap01", qi(start_q, 1) - qi(start_q, 0), 42);
        chk("b2b_gap12", qi(start_q, 2) - qi(start_q, 1), 42);
        chk("b2b_done_n", done_q.size(), 3);
        chk("b2b_done2", qi(done_q, 2), 126);
        chk("b2b_pops", rd_q.size(), 3);
        chk("b2b_empty", fifo_empty, 1);

        // Gating: no permission, no pop.
        tx_en = 1'b0;
        push(8'h5A); push(8'hC3);
        clr();
        repeat (100) cyc();
        begin
            int zeros;
            zeros = 0;
            for (int j = 0; j < 100; j++) if (txh[j] !== 1'b1) zeros++;
            chk("gate_tx_low", zeros, 0);
        end
        chk("gate_pops", rd_q.size(), 0);
        clr();
        tx_en = 1'b1;
        repeat (10) cyc();
        tx_en = 1'b0;
        repeat (80) cyc();
        decode();
        chk("gate_mid_pops", rd_q.size(), 1);
        chk("gate_mid_frames", byte_q.size(), 1);
        chk("gate_mid_byte", qi(byte_q, 0), 32'h5A);
        chk("gate_mid_done", done_q.size(), 1);
        chk("gate_left", fq.size(), 1);
        clr();
        tx_en = 1'b1;
        repeat (50) cyc();
        decode();
        chk("gate_resume_pop", qi(rd_q, 0), 0);
        chk("gate_resume_byte", qi(byte_q, 0), 32'hC3);

        // Reset during data bit 3 of 0x96 (bit 3 is 0, so the line is low).
        clr();
        push(8'h96); push(8'h69);
        repeat (19) cyc();
        chk("mid_pre_tx", tx, 0);
        chk("mid_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", tx_done, 0);
        chk("mid_rst_rd", fifo_rd_en, 0);
        repeat (2) cyc();
        rst = 1'b0;
        clr();
        repeat (50) cyc();
        decode();
        chk("mid_after_pop", qi(rd_q, 0), 0);
        chk("mid_after_frames", byte_q.size(), 1);
        chk("mid_after_byte", qi(byte_q, 0), 32'h69);
        chk("mid_after_done", qi(done_q, 0), 42);

        // Full 8-entry drain.
        tx_en = 1'b0;
        for (int b = 1; b <= 8; b++) push(8'(b));
        clr();
        tx_en = 1'b1;
        repeat (8*42 + 20) cyc();
        decode();
        chk("drain_frames", byte_q.size(), 8);
        for (int b = 0; b < 8; b++) chk($sformatf("drain_byte%0d", b), qi(byte_q, b), b + 1);
        chk("drain_pops", rd_q.size(), 8);
        chk("drain_done", done_q.size(), 8);
        chk("drain_empty", fq.size(), 0);
        chk("rd_while_empty", bad_rd, 0);
        chk("stop_bit_errs", stop_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 8-deep synchronous byte FIFO: pops one byte at a time through the FIFO read port and serializes it onto a UART line as 8N1 (1 start, 8 data LSB-first, 1 stop). It sits between the FIFO (`rd_en` / `data_out` / `rd_empty`) and the board TX pin, in the FIFO's clock domain. There is no rate matching or flow control beyond the FIFO's empty flag.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal values are 2..65535. The counter width is `$clog2(CLKS_PER_BIT)`.
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset. **Asynchronous, active-high**. One clock domain.
- `tx_en`, in, 1: permission to start a new frame. Sampled only in IDLE; a frame in flight always completes.
- `fifo_empty`, in, 1: FIFO `rd_empty`.
- `fifo_data`, in, 8: FIFO `data_out`. Registered in the FIFO; valid the cycle after an accepted `rd_en`.
- `fifo_rd_en`, out, 1: FIFO read strobe. Combinational, single-cycle.
- `tx`, out, 1: serial line. Registered; idles high.
- `busy`, out, 1: high whenever state is not IDLE (combinational from state).
- `tx_done`, out, 1: registered one-cycle pulse after each stop bit completes.

## Operation
- **States:** IDLE, FETCH, START, DATA, STOP (binary encoded; reset state is IDLE).
- **IDLE:**
  - `fifo_rd_en = tx_en & ~fifo_empty`.
  - If that term is 1, the next state is FETCH. Otherwise stay in IDLE.
  - `tx` = 1.
- **FETCH:** one cycle. Load `fifo_data` into an 8-bit shift register. Clear the bit counter and the baud counter. Next state is START.
- **START:**
  - `tx` = 0 for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1. At terminal count: clear the counter and go to DATA.
- **DATA:**
  - `tx` = shift_reg[0].
  - At each baud terminal count: shift right, bit_cnt +1. After bit_cnt reaches 7 and its terminal count, go to STOP.
  - Exactly 8 bits, each CLKS_PER_BIT cycles.
- **STOP:**
  - `tx` = 1 for CLKS_PER_BIT cycles.
  - At terminal count: go to IDLE and set `tx_done` for the following cycle.
- `fifo_rd_en` is never asserted outside IDLE. Exactly one pop occurs per frame.
- The FIFO's `fifo_empty` and `tx_en` changing during FETCH..STOP have no effect.
- **Reset (`rst`=1, any time, including mid-frame):**
  - Outputs immediately: `tx`=1, `busy`=0, `tx_done`=0, `fifo_rd_en`=0.
  - State goes to IDLE and all counters and the shift register clear.
  - A byte already popped is lost.
  - After release, the block behaves as from power-up.

## Timing
- **Cycle numbering:** cycle 0 is an IDLE cycle with `tx_en`=1 and `fifo_empty`=0, so `fifo_rd_en`=1.
  - Cycle 1: FETCH; `fifo_data` is valid and is captured at the end of the cycle.
  - Cycle 2: START; `tx` falls, since `tx` is registered off the next state.
  - Cycles 2..(2+10·CLKS_PER_BIT−1): the frame. Data bit k occupies cycles 2+(k+1)·CLKS_PER_BIT onward.
  - Cycle 2+10·CLKS_PER_BIT: IDLE, `tx_done`=1.
- **Frame period:** 10·CLKS_PER_BIT cycles on the line.
- **Back-to-back throughput:** a non-empty FIFO gives one frame every 10·CLKS_PER_BIT+2 cycles. The 2 extra cycles (IDLE+FETCH) are idle-high line time. The next pop can coincide with the `tx_done` cycle.
- **Latency:** from the IDLE pop to the start-bit edge is 2 cycles.
- **Arithmetic:** baud and bit counters compare for equality with CLKS_PER_BIT−1 and 7. There is no wrap beyond those; they are cleared explicitly.
- **Simultaneous events:** `tx_en` dropping in the same cycle as `fifo_empty` deasserting means no pop. `fifo_empty` asserting in the pop cycle is governed by its value in that cycle only.

## Test plan
- **Reset values:** hold `rst`=1 for 3 cycles with `fifo_empty`=0 and `tx_en`=1.
  - `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout.
  - The first `fifo_rd_en` appears in the first cycle after release.
- **Single byte:** CLKS_PER_BIT=4; write 0xA5 into the FIFO, then `tx_en`=1.
  - Exactly one `fifo_rd_en` pulse.
  - `tx` low 2 cycles later for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles.
  - `tx_done` pulses at cycle 42 after the pop.
- **Back-to-back:** CLKS_PER_BIT=4; FIFO holds 0x00, 0xFF, 0x3C.
  - Three frames decoded by a bench UART receiver in order.
  - Start-bit edges are 42 cycles apart; 3 `tx_done` pulses; FIFO empty afterwards with no extra `fifo_rd_en`.
- **Gating:** with `tx_en`=0 and the FIFO non-empty for 100 cycles, there is no pop and `tx` stays 1.
  - Drop `tx_en` mid-frame: the frame completes, then no further pop until `tx_en`=1.
- **Reset mid-frame:** assert `rst` during DATA bit 3.
  - `tx`=1 and `busy`=0 asynchronously.
  - After release, the next FIFO byte is sent as a complete frame.
- **Full FIFO drain:** fill 8 bytes 0x01..0x08, then `tx_en`=1.
  - 8 frames, decoded in order.
  - `fifo_rd_en` is never high while `fifo_empty`=1.
